// File: rtl/bm_if_serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter.
//   state_t        : FSM state encoding (IDLE=0 .. STOP=4, 3 bits)
//   LINE_IDLE      : level the serial line rests at between frames
//   FRAME_OVERHEAD : non-data bits per frame (start, parity, stop)
package bm_if_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE      = 1'b1;
    localparam int   FRAME_OVERHEAD = 3;

endpackage

// File: rtl/bm_if_serial_tx_if.sv
// Word-in / serial-out bundle of the transmitter.
//   en_in, valid_in, data_in : word offer from the producer (master drives)
//   ready_out                : transmitter can take a word this cycle
//   tx_out                   : serial line, idles high
//   busy_out, done_out       : frame in progress / stop-bit-cycle pulse
//
// Handshake: a word moves on a rising clock edge where ready_out, valid_in
// and en_in are all high. The producer may hold valid_in high across any
// number of cycles; ready_out never depends on valid_in, so there is no
// combinational loop between the two sides.
interface bm_if_serial_tx_if #(
    parameter int BITS = 2
);
    logic            en_in;
    logic            valid_in;
    logic [BITS-1:0] data_in;
    logic            ready_out;
    logic            tx_out;
    logic            busy_out;
    logic            done_out;

    modport master (
        output en_in, valid_in, data_in,
        input  ready_out, tx_out, busy_out, done_out
    );

    modport slave (
        input  en_in, valid_in, data_in,
        output ready_out, tx_out, busy_out, done_out
    );
endinterface

// File: rtl/bm_if_serial_tx_shift.sv
// Data path of the transmitter: load/shift register, bit counter and even
// parity generator, all steered by strobes from the FSM.
//   load    : capture data, compute parity, clear the counter
//   first   : first data bit is being emitted, counter <= 1
//   shift   : move to the next data bit, counter + 1
//   lsb     : bit currently at the bottom of the register
//   next    : bit that becomes the bottom after one shift
//   parity  : XOR of the captured word
//   count   : data bits emitted so far in this frame
module bm_if_serial_tx_shift #(
    parameter int BITS  = 2,
    parameter int CNT_W = $clog2(BITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             first,
    input  logic             shift,
    input  logic [BITS-1:0]  data,
    output logic             lsb,
    output logic             next,
    output logic             parity,
    output logic [CNT_W-1:0] count
);

    logic [BITS-1:0]  shift_q;
    logic [BITS-1:0]  shift_nx;
    logic             parity_q;
    logic [CNT_W-1:0] count_q;

    // Shifting via >> keeps this legal for BITS=1, where next is simply 0.
    assign shift_nx = shift_q >> 1;

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q  <= '0;
            parity_q <= 1'b0;
            count_q  <= '0;
        end else if (load) begin
            shift_q  <= data;
            parity_q <= ^data;
            count_q  <= '0;
        end else if (first) begin
            count_q  <= CNT_W'(1);
        end else if (shift) begin
            shift_q  <= shift_nx;
            count_q  <= count_q + CNT_W'(1);
        end
    end

    assign lsb    = shift_q[0];
    assign next   = shift_nx[0];
    assign parity = parity_q;
    assign count  = count_q;

endmodule

// File: rtl/bm_if_serial_tx.sv
// Serial frame transmitter: takes a BITS-wide word over the handshake and
// sends start(0), data LSB-first, even parity, stop(1); one bit per clock.
//   clock, reset : clock and synchronous active-high reset
//   bus          : handshake and serial outputs (slave side)
//   state_dbg    : current FSM state, for observation only
module bm_if_serial_tx
    import bm_if_serial_tx_pkg::*;
#(
    parameter int BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    bm_if_serial_tx_if.slave      bus,
    output state_t                state_dbg
);

    localparam int               CNT_W    = $clog2(BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS);

    state_t           state_q, state_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load, first, shift;
    logic             lsb, next, parity;
    logic [CNT_W-1:0] count;
    logic             ready;
    logic             accept;

    bm_if_serial_tx_shift #(
        .BITS  (BITS),
        .CNT_W (CNT_W)
    ) u_shift (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .first  (first),
        .shift  (shift),
        .data   (bus.data_in),
        .lsb    (lsb),
        .next   (next),
        .parity (parity),
        .count  (count)
    );

    // STOP also accepts so consecutive frames run with no idle gap.
    assign ready  = (state_q == IDLE) || (state_q == STOP);
    assign accept = ready && bus.valid_in && bus.en_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        first   = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d = START;
                    load    = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    tx_d    = LINE_IDLE;
                    busy_d  = 1'b0;
                end
            end
            START: begin
                state_d = DATA;
                first   = 1'b1;
                tx_d    = lsb;
            end
            DATA: begin
                // count is the number of data bits already on the line.
                if (count < LAST_CNT) begin
                    shift = 1'b1;
                    tx_d  = next;
                end else begin
                    state_d = PARITY;
                    tx_d    = parity;
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = LINE_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                tx_d    = LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.ready_out = ready;
    assign bus.tx_out    = tx_q;
    assign bus.busy_out  = busy_q;
    assign bus.done_out  = done_q;
    assign state_dbg     = state_q;

endmodule
